diff_word: RTL and testbench

- Differential encoder stage that sits directly upstream of the digit-removal stage.
- Accepts an N-digit DNA word (2 bits per digit) on a start strobe.
- Converts each digit to its mod-4 difference from the previous digit, processing K digits per cycle.
- Presents the differential word and its length, held stable, with a one-cycle done pulse.

---
 rtl/dna_pkg.sv | 13 +
 rtl/diff_word_if.sv | 22 ++
 rtl/diff_word_chunk.sv | 28 ++
 rtl/diff_word.sv | 92 +++++++++
 tb/tb_diff_word.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/dna_pkg.sv
// Shared DNA digit types, FSM states and the mod-4 digit differencer.
package dna_pkg;
  localparam int DIGIT_W = 2;
  localparam int N_DEF   = 98;

  typedef logic [DIGIT_W-1:0] digit_t;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  // 2-bit result width makes the subtract wrap mod 4.
  function automatic digit_t digit_diff(digit_t a, digit_t b);
    return a - b;
  endfunction
endpackage

// File: rtl/diff_word_if.sv
// Start/word bus between a word source and the differential encoder.
interface diff_word_if #(
  parameter int N     = 98,
  parameter int LEN_W = 7
);
  logic             start;
  logic [2*N-1:0]   word_in;
  logic [LEN_W-1:0] word_in_len;
  logic             busy;
  logic             done;
  logic [2*N-1:0]   word_out;
  logic [LEN_W-1:0] word_out_len;

  modport master (
    output start, word_in, word_in_len,
    input  busy, done, word_out, word_out_len
  );
  modport slave (
    input  start, word_in, word_in_len,
    output busy, done, word_out, word_out_len
  );
endinterface

// File: rtl/diff_word_chunk.sv
// Combinational K-digit differencer; digits at or beyond len produce 00.
module diff_chunk
  import dna_pkg::*;
#(
  parameter int K     = 7,
  parameter int LEN_W = 7
) (
  input  digit_t [K-1:0]   w,
  input  digit_t           prev,
  input  logic [LEN_W-1:0] base,
  input  logic [LEN_W-1:0] len,
  output digit_t [K-1:0]   d,
  output digit_t           last
);
  for (genvar j = 0; j < K; j++) begin : g_lane
    logic [LEN_W:0] idx;
    digit_t         p;
    assign idx = {1'b0, base} + (LEN_W+1)'(j);
    if (j == 0) begin : g_first
      assign p = prev;
    end else begin : g_rest
      assign p = w[j-1];
    end
    assign d[j] = (idx < {1'b0, len}) ? digit_diff(w[j], p) : '0;
  end

  assign last = w[K-1];
endmodule

// File: rtl/diff_word.sv
// Differential encoder: one K-digit chunk per RUN cycle, then a one-cycle DONE.
module diff_word
  import dna_pkg::*;
#(
  parameter int     N     = N_DEF,
  parameter int     K     = 7,
  parameter digit_t SEED  = 2'b00,
  parameter int     LEN_W = 7
) (
  input  logic      clk,
  input  logic      rst,
  diff_word_if.slave bus
);
  localparam int              NCH  = N / K;
  localparam int              CW   = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [CW-1:0]   LAST = CW'(NCH - 1);
  localparam logic [LEN_W-1:0] NLEN = LEN_W'(N);

  state_t                    state;
  digit_t [NCH-1:0][K-1:0]   shadow;
  digit_t [NCH-1:0][K-1:0]   out_q;
  logic [CW-1:0]             chunk;
  digit_t                    prev;
  logic [LEN_W-1:0]          len_q;
  logic [LEN_W-1:0]          len_out_q;
  logic                      busy_q;
  logic                      done_q;

  digit_t [K-1:0]            d;
  digit_t                    last;
  logic [LEN_W-1:0]          base;

  assign base = LEN_W'(int'(chunk) * K);

  diff_chunk #(.K(K), .LEN_W(LEN_W)) u_chunk (
    .w    (shadow[chunk]),
    .prev (prev),
    .base (base),
    .len  (len_q),
    .d    (d),
    .last (last)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      shadow    <= '0;
      out_q     <= '0;
      chunk     <= '0;
      prev      <= '0;
      len_q     <= '0;
      len_out_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          shadow <= bus.word_in;
          len_q  <= (bus.word_in_len > NLEN) ? NLEN : bus.word_in_len;
          prev   <= SEED;
          chunk  <= '0;
          out_q  <= '0;
          busy_q <= 1'b1;
          state  <= RUN;
        end
        RUN: begin
          out_q[chunk] <= d;
          // last digit of this chunk seeds digit 0 of the next
          prev <= last;
          if (chunk == LAST) begin
            len_out_q <= len_q;
            done_q    <= 1'b1;
            state     <= DONE;
          end else begin
            chunk <= chunk + 1'b1;
          end
        end
        DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.busy         = busy_q;
  assign bus.done         = done_q;
  assign bus.word_out     = out_q;
  assign bus.word_out_len = len_out_q;
endmodule

// File: tb/tb_diff_word.sv
// Directed-vector bench for diff_word with hand-computed expectations.
module tb_diff_word;
  localparam int N = 98;
  localparam int W = 2 * N;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  diff_word_if #(.N(N), .LEN_W(7)) bus ();

  diff_word #(.N(N), .K(7), .SEED(2'b00), .LEN_W(7)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Called on the first negedge after the start edge; k counts negedges from there.
  task automatic wait_done(output int k, output int bc);
    k  = 1;
    bc = 0;
    while (!bus.done && k < 40) begin
      if (bus.busy) bc++;
      @(negedge clk);
      k++;
    end
  endtask

  task automatic do_word(input string tag, input logic [W-1:0] w, input logic [6:0] l);
    int k, bc;
    bus.word_in     = w;
    bus.word_in_len = l;
    bus.start       = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk({tag, "_clr"}, 256'(bus.word_out), 256'd0);
    wait_done(k, bc);
    chk({tag, "_lat"}, 256'(k - 1), 256'd14);
    chk({tag, "_busy"}, 256'(bc), 256'd14);
    chk({tag, "_busy_done"}, 256'(bus.busy), 256'd1);
    @(negedge clk);
    chk({tag, "_done_fall"}, 256'({bus.done, bus.busy}), 256'd0);
  endtask

  initial begin
    logic [W-1:0] w, e, ramp_w, ramp_e, bnd_w;
    int k, bc;
    n_vec = 0;
    n_err = 0;
    rst = 1'b0;
    bus.start = 1'b0;
    bus.word_in = '0;
    bus.word_in_len = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 256'(bus.busy), 256'd0);
    chk("rst_done", 256'(bus.done), 256'd0);
    chk("rst_word", 256'(bus.word_out), 256'd0);
    chk("rst_len", 256'(bus.word_out_len), 256'd0);
    rst = 1'b1;
    @(negedge clk);

    // zero word
    do_word("zero", '0, 7'd98);
    chk("zero_word", 256'(bus.word_out), 256'd0);
    chk("zero_len", 256'(bus.word_out_len), 256'd98);

    // ramp 1,2,3,0 -> 1,1,1,1,0
    ramp_w = '0; ramp_w[1:0] = 2'd1; ramp_w[3:2] = 2'd2; ramp_w[5:4] = 2'd3;
    ramp_e = '0; ramp_e[1:0] = 2'd1; ramp_e[3:2] = 2'd1; ramp_e[5:4] = 2'd1; ramp_e[7:6] = 2'd1;
    do_word("ramp", ramp_w, 7'd98);
    chk("ramp_word", 256'(bus.word_out), 256'(ramp_e));

    // chunk boundary: d6=2, d7=3, d8=3
    bnd_w = '0; bnd_w[13:12] = 2'd2; bnd_w[15:14] = 2'd1;
    e = '0; e[13:12] = 2'd2; e[15:14] = 2'd3; e[17:16] = 2'd3;
    do_word("bnd", bnd_w, 7'd98);
    chk("bnd_word", 256'(bus.word_out), 256'(e));

    // length cut: digit i = i mod 4
    w = '0;
    for (int i = 0; i < N; i++) w[2*i +: 2] = 2'(i % 4);
    e = '0;
    for (int i = 1; i < 5; i++) e[2*i +: 2] = 2'd1;
    do_word("len5", w, 7'd5);
    chk("len5_word", 256'(bus.word_out), 256'(e));
    chk("len5_len", 256'(bus.word_out_len), 256'd5);
    e = '0;
    for (int i = 1; i < N; i++) e[2*i +: 2] = 2'd1;
    do_word("len120", w, 7'd120);
    chk("len120_word", 256'(bus.word_out), 256'(e));
    chk("len120_len", 256'(bus.word_out_len), 256'd98);

    // len=0
    do_word("len0", w, 7'd0);
    chk("len0_word", 256'(bus.word_out), 256'd0);
    chk("len0_len", 256'(bus.word_out_len), 256'd0);

    // start during RUN is ignored
    bus.word_in = ramp_w; bus.word_in_len = 7'd98; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (2) @(negedge clk);
    bus.word_in = bnd_w; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done(k, bc);
    chk("ign_lat", 256'(k + 2), 256'd14);
    chk("ign_word", 256'(bus.word_out), 256'(ramp_e));
    @(negedge clk);
    chk("ign_idle", 256'(bus.busy), 256'd0);
    @(negedge clk);

    // start held high: ramp then boundary word, one idle cycle between
    bus.word_in = ramp_w; bus.start = 1'b1;
    @(negedge clk);
    wait_done(k, bc);
    chk("held1_lat", 256'(k - 1), 256'd14);
    chk("held1_word", 256'(bus.word_out), 256'(ramp_e));
    bus.word_in = bnd_w;
    @(negedge clk);
    chk("held_idle", 256'(bus.busy), 256'd0);
    chk("held_hold", 256'(bus.word_out), 256'(ramp_e));
    @(negedge clk);
    chk("held2_acc", 256'({bus.busy, bus.word_out}), {59'd0, 1'b1, 196'd0});
    wait_done(k, bc);
    bus.start = 1'b0;
    e = '0; e[13:12] = 2'd2; e[15:14] = 2'd3; e[17:16] = 2'd3;
    chk("held2_lat", 256'(k - 1), 256'd14);
    chk("held2_word", 256'(bus.word_out), 256'(e));
    @(negedge clk);
    @(negedge clk);

    // reset abort mid-RUN
    bus.word_in = ramp_w; bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("abort_pre", 256'(bus.word_out[1:0]), 256'd1);
    #2 rst = 1'b0;
    #1;
    chk("abort_busy", 256'(bus.busy), 256'd0);
    chk("abort_done", 256'(bus.done), 256'd0);
    chk("abort_word", 256'(bus.word_out), 256'd0);
    chk("abort_len", 256'(bus.word_out_len), 256'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    do_word("post", ramp_w, 7'd98);
    chk("post_word", 256'(bus.word_out), 256'(ramp_e));
    chk("post_len", 256'(bus.word_out_len), 256'd98);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
